// File: rtl/cursor_control_if.sv
// -----------------------------------------------------------------------------
// cursor_control_if
// Purpose : Bundles the push-button inputs and the cursor outputs of
//           cursor_control so they travel as a single port.
// Signals :
//   up, down, left, right : raw asynchronous push-buttons, active-high
//   cursorCor  [6:0]      : linear grid address row*10+col (0..99)
//   cursorRow  [3:0]      : current row (0..9)
//   cursorCol  [3:0]      : current column (0..9)
//   moved                 : one-cycle pulse in the cycle the cursor updates
// Modports:
//   master : button source / cursor consumer (testbench, board top)
//   slave  : the cursor_control block itself
// -----------------------------------------------------------------------------
interface cursor_control_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [6:0] cursorCor;
    logic [3:0] cursorRow;
    logic [3:0] cursorCol;
    logic       moved;

    modport master (
        output up, down, left, right,
        input  cursorCor, cursorRow, cursorCol, moved
    );

    modport slave (
        input  up, down, left, right,
        output cursorCor, cursorRow, cursorCol, moved
    );
endinterface

// File: rtl/cursor_control.sv
// -----------------------------------------------------------------------------
// cursor_control
// Purpose : Moves a cursor over a 10x10 grid from four push-buttons. Each
//           button is synchronized (2 flops), debounced by its own FSM and
//           turned into single-cycle step requests. Simultaneous requests are
//           resolved with priority up > down > left > right; moves wrap at
//           the grid edges.
// Ports   :
//   clk    : system clock
//   reset  : synchronous active-high reset
//   bus    : cursor_control_if.slave (buttons in, cursor position/moved out)
// Parameters:
//   DEBOUNCE_CYCLES : cycles a level must be stable before it is accepted
//   REPEAT_DELAY    : cycles held before the first auto-repeat
//   REPEAT_PERIOD   : cycles between subsequent auto-repeats
// Build option:
//   CURSOR_AUTOREPEAT_EN : when defined, a held button issues extra steps
//                          after REPEAT_DELAY and then every REPEAT_PERIOD.
//                          When undefined, one step per debounced press and
//                          no repeat logic is built.
// -----------------------------------------------------------------------------
module cursor_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic              clk,
    input  logic              reset,
    cursor_control_if.slave   bus
);

    // Counter width comes from the largest count parameter so every
    // configuration can reach its terminal count.
    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Terminal values: the counter starts at 0, so N cycles end at N-1.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef CURSOR_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    // Button index order used throughout: 0=up, 1=down, 2=left, 3=right.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

    logic [3:0] btn_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] step_req;

    assign btn_raw = {bus.right, bus.left, bus.down, bus.up};

    // Two-flop synchronizer ahead of all other logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Per-button debounce FSM. The single counter is shared between the
    // debounce windows (PRESS_WAIT / REL_WAIT) and, when auto-repeat is
    // built, the repeat timer in HELD, since those never overlap.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        db_state_t        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_inc;
        logic             step_q;
`ifdef CURSOR_AUTOREPEAT_EN
        logic             rep_first_q;  // first repeat (after REPEAT_DELAY) done
`endif

        // Saturating increment: never wraps back to zero.
        assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                step_q      <= 1'b0;
`ifdef CURSOR_AUTOREPEAT_EN
                rep_first_q <= 1'b0;
`endif
            end else begin
                step_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (sync2_q[gi]) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2_q[gi]) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q     <= HELD;
                            step_q      <= 1'b1;
                            cnt_q       <= '0;
`ifdef CURSOR_AUTOREPEAT_EN
                            rep_first_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    HELD: begin
                        if (!sync2_q[gi]) begin
                            state_q <= REL_WAIT;
                            cnt_q   <= '0;
`ifdef CURSOR_AUTOREPEAT_EN
                        end else if ((!rep_first_q && cnt_q == RD_LAST) ||
                                     ( rep_first_q && cnt_q == RP_LAST)) begin
                            step_q      <= 1'b1;
                            cnt_q       <= '0;
                            rep_first_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
`endif
                        end
                    end
                    REL_WAIT: begin
                        // A bounce back to 1 returns to HELD silently; the
                        // repeat timer restarts from scratch.
                        if (sync2_q[gi]) begin
                            state_q     <= HELD;
                            cnt_q       <= '0;
`ifdef CURSOR_AUTOREPEAT_EN
                            rep_first_q <= 1'b0;
`endif
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign step_req[gi] = step_q;
    end

    // -------------------------------------------------------------------------
    // Cursor position: one move per cycle, highest-priority request wins.
    // -------------------------------------------------------------------------
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [6:0] cor_q, cor_d;
    logic       moved_q, moved_d;

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        moved_d = 1'b0;
        if (step_req[BTN_UP]) begin
            row_d   = (row_q == 4'd0) ? 4'd9 : row_q - 4'd1;
            moved_d = 1'b1;
        end else if (step_req[BTN_DOWN]) begin
            row_d   = (row_q >= 4'd9) ? 4'd0 : row_q + 4'd1;
            moved_d = 1'b1;
        end else if (step_req[BTN_LEFT]) begin
            col_d   = (col_q == 4'd0) ? 4'd9 : col_q - 4'd1;
            moved_d = 1'b1;
        end else if (step_req[BTN_RIGHT]) begin
            col_d   = (col_q >= 4'd9) ? 4'd0 : col_q + 4'd1;
            moved_d = 1'b1;
        end
        // Linear address computed from the next coordinates so all three
        // outputs change in the same cycle.
        cor_d = 7'(row_d) * 7'd10 + 7'(col_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            cor_q   <= 7'd0;
            moved_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            cor_q   <= cor_d;
            moved_q <= moved_d;
        end
    end

    assign bus.cursorRow = row_q;
    assign bus.cursorCol = col_q;
    assign bus.cursorCor = cor_q;
    assign bus.moved     = moved_q;

endmodule

// File: tb/tb_cursor_control.sv
module tb_cursor_control;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   move_cnt;
    int   double_pulse_cnt;
    logic moved_prev;

    cursor_control_if bus();

    cursor_control #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count moved pulses and flag any pulse wider than one cycle.
    always @(negedge clk) begin
        if (bus.moved) move_cnt++;
        if (bus.moved && moved_prev) double_pulse_cnt++;
        moved_prev = bus.moved;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    task automatic set_btns(input logic [3:0] mask);
        bus.up    = mask[0];
        bus.down  = mask[1];
        bus.left  = mask[2];
        bus.right = mask[3];
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the given buttons n cycles, release, then let the FSM settle to IDLE.
    task automatic press(input logic [3:0] mask, input int n);
        @(posedge clk); #1;
        set_btns(mask);
        wait_cycles(n);
        set_btns(4'b0000);
        wait_cycles(14);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);
    endtask

    task automatic check_pos(input string tag, input int row, input int col);
        @(negedge clk);
        check({tag, ".row"}, int'(bus.cursorRow), row);
        check({tag, ".col"}, int'(bus.cursorCol), col);
        check({tag, ".cor"}, int'(bus.cursorCor), row * 10 + col);
    endtask

    localparam logic [3:0] M_UP    = 4'b0001;
    localparam logic [3:0] M_DOWN  = 4'b0010;
    localparam logic [3:0] M_LEFT  = 4'b0100;
    localparam logic [3:0] M_RIGHT = 4'b1000;

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        move_cnt         = 0;
        double_pulse_cnt = 0;
        moved_prev       = 1'b0;
        reset            = 1'b0;
        set_btns(4'b0000);

        // Reset state
        do_reset();
        check_pos("reset", 0, 0);
        @(negedge clk);
        check("reset.moved", int'(bus.moved), 0);

        // Right held 10 cycles -> exactly one step
        move_cnt = 0;
        press(M_RIGHT, 10);
        check("right10.moves", move_cnt, 1);
        check_pos("right10", 0, 1);

        // Right held only 3 cycles -> rejected by debounce
        move_cnt = 0;
        press(M_RIGHT, 3);
        check("right3.moves", move_cnt, 0);
        check_pos("right3", 0, 1);

        // Wrap from (0,0): up -> (9,0), left -> (9,9)
        do_reset();
        press(M_UP, 10);
        check_pos("up_wrap", 9, 0);
        press(M_LEFT, 10);
        check_pos("left_wrap", 9, 9);
        // Opposite edges: down from row 9, right from col 9
        press(M_DOWN, 10);
        check_pos("down_wrap", 0, 9);
        press(M_RIGHT, 10);
        check_pos("right_wrap", 0, 0);

        // Walk to (5,5): up x5 gives 9,8,7,6,5; right x5 gives col 5
        for (int i = 0; i < 5; i++) press(M_UP, 10);
        for (int i = 0; i < 5; i++) press(M_RIGHT, 10);
        check_pos("walk55", 5, 5);

        // Up and right together: up wins, right discarded
        move_cnt = 0;
        press(M_UP | M_RIGHT, 10);
        check("prio.moves", move_cnt, 1);
        check_pos("prio", 4, 5);

        // Down held 60 cycles
        move_cnt = 0;
        press(M_DOWN, 60);
`ifdef CURSOR_AUTOREPEAT_EN
        // initial step + repeats 20 cycles into HELD then every 8: 6 moves
        check("hold60.moves", move_cnt, 6);
        check_pos("hold60", 0, 5);
`else
        check("hold60.moves", move_cnt, 1);
        check_pos("hold60", 5, 5);
`endif

        // Reset 2 cycles into PRESS_WAIT of left at col 3 cancels the step
        do_reset();
        for (int i = 0; i < 3; i++) press(M_RIGHT, 10);
        check_pos("col3", 0, 3);
        move_cnt = 0;
        @(posedge clk); #1;
        set_btns(M_LEFT);
        wait_cycles(5);          // 2 sync + IDLE sample + 2 cycles in PRESS_WAIT
        reset = 1'b1;
        wait_cycles(1);
        set_btns(4'b0000);
        reset = 1'b0;
        wait_cycles(20);
        check("cancel.moves", move_cnt, 0);
        check_pos("cancel", 0, 0);

        // Button still held across reset -> treated as a fresh press, one step
        move_cnt = 0;
        @(posedge clk); #1;
        set_btns(M_LEFT);
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(12);
        set_btns(4'b0000);
        wait_cycles(14);
        check("fresh.moves", move_cnt, 1);
        check_pos("fresh", 0, 9);

        check("moved.width", double_pulse_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
